// File: rtl/mem_access.sv
// mem_access: memory-stage bus access unit, one load/store per transaction
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   in_valid/in_ready      op handshake from the pipeline (mem_read, mem_write, addr, msize, mem_unsigned, wdata)
//   dreq_*                 data-bus request (valid, addr, size, strobe, lane-aligned store data)
//   dresp_*                data-bus response (addr_ok, data_ok, read word)
//   out_valid/out_ready    result handshake to load extraction (rdata, addr_lo, msize, unsigned, misalign)
package common;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
endpackage

module mem_access
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  msize_t      msize,
  input  logic        mem_unsigned,
  input  logic [63:0] wdata,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic [2:0]  out_addr_lo,
  output msize_t      out_msize,
  output logic        out_unsigned,
  output logic        out_misalign
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, data_q, rdata_q;
  logic [7:0] strobe_q;
  msize_t size_q;
  logic unsigned_q, read_q, misalign_q;
  logic [2:0] a;
  logic mis, accept, capture;
  logic [7:0] strb;
  assign a = addr[2:0];
  assign mis = (msize == MSIZE2 && a[0]) || (msize == MSIZE4 && a[1:0] != 2'd0) ||
               (msize == MSIZE8 && a != 3'd0);
  assign strb = !mem_write ? 8'h00 :
                msize == MSIZE8 ? 8'hff :
                msize == MSIZE4 ? 8'h0f << a :
                msize == MSIZE2 ? 8'h03 << a : 8'h01 << a;
  assign accept = state_q == IDLE && in_valid;
  // both response beats may land together in ADDR; data_ok alone in ADDR is ignored
  assign capture = (state_q == ADDR && dresp_addr_ok && dresp_data_ok) ||
                   (state_q == DATA && dresp_data_ok);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !in_valid ? IDLE : (mis || !(mem_read || mem_write)) ? HOLD : ADDR;
      ADDR: state_d = !dresp_addr_ok ? ADDR : dresp_data_ok ? HOLD : DATA;
      DATA: state_d = dresp_data_ok ? HOLD : DATA;
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == IDLE;
    dreq_valid = state_q == ADDR;
    out_valid = state_q == HOLD;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_q <= '0;
      size_q <= MSIZE1;
      unsigned_q <= 1'b0;
      read_q <= 1'b0;
      strobe_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      addr_q <= addr;
      size_q <= msize;
      unsigned_q <= mem_unsigned;
      read_q <= mem_read;
      strobe_q <= strb;
      data_q <= mem_write ? wdata << {a, 3'b000} : 64'd0;
      rdata_q <= '0;
      misalign_q <= mis;
    end else if (capture && read_q) begin
      rdata_q <= dresp_data;
    end
  assign dreq_addr = addr_q;
  assign dreq_size = size_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data = data_q;
  assign out_rdata = rdata_q;
  assign out_addr_lo = addr_q[2:0];
  assign out_msize = size_q;
  assign out_unsigned = unsigned_q;
  assign out_misalign = misalign_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access
module tb_mem_access;
  import common::*;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
  logic [63:0] addr = '0, wdata = '0, dresp_data = '0;
  msize_t msize = MSIZE1;
  logic dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0, out_ready = 1'b0;
  logic in_ready, dreq_valid, out_valid, out_unsigned, out_misalign;
  logic [63:0] dreq_addr, dreq_data, out_rdata;
  msize_t dreq_size, out_msize;
  logic [7:0] dreq_strobe;
  logic [2:0] out_addr_lo;
  int checks = 0, errors = 0;
  mem_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .msize(msize),
    .mem_unsigned(mem_unsigned), .wdata(wdata), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_addr_lo(out_addr_lo), .out_msize(out_msize),
    .out_unsigned(out_unsigned), .out_misalign(out_misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rd, input logic wr, input logic [63:0] ad,
                       input msize_t sz, input logic un, input logic [63:0] wd);
    mem_read = rd;
    mem_write = wr;
    addr = ad;
    msize = sz;
    mem_unsigned = un;
    wdata = wd;
    in_valid = 1'b1;
    chk("accept_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    addr = 64'hdead_beef_dead_beef;
    wdata = 64'hffff_ffff_ffff_ffff;
  endtask
  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
  endtask
  initial begin
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    reset = 1'b1;
    step();
    // LB, bus answers both beats in first ADDR cycle
    issue(1'b1, 1'b0, 64'h8000_0005, MSIZE1, 1'b0, 64'h0);
    chk("lb_dreq_valid", 64'(dreq_valid), 64'd1);
    chk("lb_in_ready", 64'(in_ready), 64'd0);
    chk("lb_strobe", 64'(dreq_strobe), 64'h00);
    chk("lb_dreq_addr", dreq_addr, 64'h8000_0005);
    chk("lb_dreq_data", dreq_data, 64'h0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h1122_3344_5566_7788;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    chk("lb_out_valid", 64'(out_valid), 64'd1);
    chk("lb_dreq_valid_off", 64'(dreq_valid), 64'd0);
    chk("lb_rdata", out_rdata, 64'h1122_3344_5566_7788);
    chk("lb_addr_lo", 64'(out_addr_lo), 64'd5);
    chk("lb_misalign", 64'(out_misalign), 64'd0);
    drain();
    // SH to lane 6
    issue(1'b0, 1'b1, 64'h8000_0006, MSIZE2, 1'b0, 64'hABCD);
    chk("sh_strobe", 64'(dreq_strobe), 64'hC0);
    chk("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
    chk("sh_size", 64'(dreq_size), 64'(MSIZE2));
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h5555_5555_5555_5555;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    chk("sh_out_valid", 64'(out_valid), 64'd1);
    chk("sh_rdata", out_rdata, 64'h0);
    chk("sh_misalign", 64'(out_misalign), 64'd0);
    drain();
    // misaligned LW
    issue(1'b1, 1'b0, 64'h8000_0002, MSIZE4, 1'b1, 64'h0);
    chk("lw_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("lw_out_valid", 64'(out_valid), 64'd1);
    chk("lw_misalign", 64'(out_misalign), 64'd1);
    chk("lw_unsigned", 64'(out_unsigned), 64'd1);
    drain();
    // neither read nor write
    issue(1'b0, 1'b0, 64'h10, MSIZE8, 1'b0, 64'h0);
    chk("nop_out_valid", 64'(out_valid), 64'd1);
    chk("nop_misalign", 64'(out_misalign), 64'd0);
    chk("nop_dreq_valid", 64'(dreq_valid), 64'd0);
    drain();
    // split handshake on LD; stray data_ok in ADDR must be ignored
    issue(1'b1, 1'b0, 64'h8000_1008, MSIZE8, 1'b0, 64'h0);
    dresp_data_ok = 1'b1;
    dresp_data = 64'hbad0_bad0_bad0_bad0;
    step();
    dresp_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("split_addr_valid", 64'(dreq_valid), 64'd1);
      chk("split_addr_stable", dreq_addr, 64'h8000_1008);
      chk("split_size_stable", 64'(dreq_size), 64'(MSIZE8));
      chk("split_no_out", 64'(out_valid), 64'd0);
      step();
    end
    chk("split_addr_valid3", 64'(dreq_valid), 64'd1);
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    chk("split_data_dreq_off", 64'(dreq_valid), 64'd0);
    chk("split_data_no_out", 64'(out_valid), 64'd0);
    step();
    chk("split_data_wait", 64'(out_valid), 64'd0);
    dresp_data_ok = 1'b1;
    dresp_data = 64'h0102_0304_0506_0708;
    step();
    dresp_data_ok = 1'b0;
    dresp_data = 64'h0;
    // backpressure in HOLD
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_rdata", out_rdata, 64'h0102_0304_0506_0708);
      chk("bp_msize", 64'(out_msize), 64'(MSIZE8));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    drain();
    // next op accepted in the IDLE cycle right after release; reset lands in DATA
    issue(1'b0, 1'b1, 64'h8000_2003, MSIZE1, 1'b0, 64'h5A);
    chk("sb_strobe", 64'(dreq_strobe), 64'h08);
    chk("sb_data", dreq_data, 64'h5A00_0000);
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    chk("rd_in_data", 64'(dreq_valid), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_strobe", 64'(dreq_strobe), 64'h0);
    chk("async_addr", dreq_addr, 64'h0);
    chk("async_data", dreq_data, 64'h0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    step();
    reset = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h7777_7777_7777_7777;
    step();
    dresp_data_ok = 1'b0;
    chk("late_in_ready", 64'(in_ready), 64'd1);
    chk("late_out_valid", 64'(out_valid), 64'd0);
    chk("late_rdata", out_rdata, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage bus access unit. Accepts one load/store per transaction from the pipeline, checks alignment, and builds the byte strobe and lane-shifted store data. It drives the data-bus request, holds it until the bus accepts and returns, then presents the raw 64-bit read word with `addr[2:0]`, `msize` and `mem_unsigned` to the downstream load-extraction logic. It sits between the execute/memory pipeline register and the load sign/zero-extension block.

## Interface
- No parameters; widths fixed (XLEN 64, bus 64-bit, `msize_t` from `common`).
- `clk  input  1  clock, rising edge`
- `reset  input  1  asynchronous, active-low (0 = reset asserted)`
- `in_valid  input  1  memory-stage op offered`
- `in_ready  output  1  op accepted this cycle`
- `mem_read  input  1  load`
- `mem_write  input  1  store (never both with mem_read)`
- `addr  input  64  effective address`
- `msize  input  msize_t  access size: MSIZE1/2/4/8`
- `mem_unsigned  input  1  LBU/LHU/LWU`
- `wdata  input  64  store source, value in low bytes`
- `dreq_valid  output  1  bus request valid`
- `dreq_addr  output  64  request address, full `addr``
- `dreq_size  output  msize_t  request size`
- `dreq_strobe  output  8  byte enables, 0 for loads`
- `dreq_data  output  64  lane-aligned store data`
- `dresp_addr_ok  input  1  bus accepted request`
- `dresp_data_ok  input  1  bus completed`
- `dresp_data  input  64  read word`
- `out_valid  output  1  result available`
- `out_ready  input  1  downstream takes result`
- `out_rdata  output  64  raw read word, 0 for stores`
- `out_addr_lo  output  3  `addr[2:0]` of the op`
- `out_msize  output  msize_t  size of the op`
- `out_unsigned  output  1  `mem_unsigned` of the op`
- `out_misalign  output  1  alignment fault, no bus access made`

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD.
- IDLE: `in_ready`=1. On `in_valid`, register all inputs and compute strobe, data and misalign. The next state depends on the op:
  - Misaligned → HOLD with `out_misalign`=1.
  - Neither read nor write → HOLD.
  - Otherwise → ADDR.
- Misaligned means `addr[0]`≠0 for MSIZE2, `addr[1:0]`≠0 for MSIZE4, or `addr[2:0]`≠0 for MSIZE8. MSIZE1 is never misaligned.
- ADDR: `dreq_valid`=1. All `dreq_*` fields are held stable until `dresp_addr_ok`.
  - `addr_ok` without `data_ok` → DATA.
  - `addr_ok` and `data_ok` in the same cycle → HOLD, capturing data.
  - `data_ok` without `addr_ok` is ignored.
- DATA: `dreq_valid`=0. On `dresp_data_ok` → HOLD. For loads, `dresp_data` is captured into `out_rdata`; for stores, `out_rdata`=0.
- HOLD: `out_valid`=1 and all `out_*` stay stable. On `out_ready` → IDLE. There is no same-cycle re-accept.
- Strobe: MSIZE1 = 8'h01<<a, MSIZE2 = 8'h03<<a, MSIZE4 = 8'h0f<<a, MSIZE8 = 8'hff, where a=`addr[2:0]`.
- Store data: `wdata` << (8·a), truncated to 64 bits. Loads: strobe 0, `dreq_data` 0.
- Bus response inputs are ignored in IDLE and HOLD.

## Timing
- Reset (asynchronous, any state): state=IDLE, `dreq_valid`=0, `out_valid`=0, and all registered data/strobe/addr/size/flag outputs =0. An outstanding bus transaction is abandoned; the bus is reset in the same domain.
- `in_ready` is combinational from state only and does not depend on `in_valid`.
- `dreq_valid` first rises the cycle after acceptance. It is registered, never combinational from inputs.
- Minimum latency from accept to `out_valid` for a bus op is 2 cycles: accept, then ADDR with `addr_ok`+`data_ok`, then HOLD.
- Misaligned or non-memory ops reach `out_valid` 1 cycle after accept.
- `out_valid` stays high until `out_ready` is sampled high. There is no timeout.

## Test plan
- Aligned LB, `addr`=0x8000_0005, MSIZE1, bus gives `addr_ok`+`data_ok` in first ADDR cycle with data 0x1122_3344_5566_7788:
  - `dreq_strobe`=0, `dreq_addr`=0x8000_0005.
  - `out_valid` 2 cycles after accept, `out_rdata`=0x1122_3344_5566_7788, `out_addr_lo`=5.
- SH, `addr`=0x...06, `wdata`=0xABCD:
  - `dreq_strobe`=8'hC0, `dreq_data`=0xABCD_0000_0000_0000.
  - `out_rdata`=0, `out_misalign`=0.
- LW at `addr`=0x...02 (MSIZE4):
  - `dreq_valid` never rises.
  - `out_misalign`=1 one cycle after accept.
- Split handshake, `addr_ok` delayed 3 cycles and `data_ok` 2 cycles later:
  - `dreq_*` stay constant through ADDR, `dreq_valid` drops in DATA.
  - `data_ok` asserted while in ADDR without `addr_ok` has no effect.
- Backpressure, `out_ready` held 0 for 4 cycles in HOLD:
  - Outputs stay stable and `in_ready`=0.
  - The IDLE cycle after `out_ready`=1 accepts the next op.
- Reset pulled low in DATA:
  - Outputs zero immediately, without waiting for a clock edge.
  - After release, `in_ready`=1 and a late `data_ok` is ignored.
